// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the pixel-stream record.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int CNT_W      = 11;
  localparam logic [11:0] SPR_KEY_DEFAULT = 12'h0F0;

  typedef struct packed {
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [11:0]      rgb;
  } vga_t;

  // Zero-extend a 12-bit coordinate into the 13-bit compare domain.
  function automatic logic [12:0] ext13(input logic [11:0] v);
    return {1'b0, v};
  endfunction
endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between pipeline stages.
interface vga_if;
  import vga_pkg::*;
  logic [CNT_W-1:0] vcount;
  logic             vsync;
  logic             vblnk;
  logic [CNT_W-1:0] hcount;
  logic             hsync;
  logic             hblnk;
  logic [11:0]      rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/sprite_unit.sv
// One sprite channel: frame-shadowed position, hit test, ROM address and hit delay.
module sprite_unit
  import vga_pkg::*;
#(
  parameter int SPR_W  = 48,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [11:0]         xpos,
  input  logic [11:0]         ypos,
  input  logic                en,
  input  logic                mirror,
  input  logic [CNT_W-1:0]    hcount,
  input  logic [CNT_W-1:0]    vcount,
  input  logic                blank,
  output logic                hit_d,
  output logic [ADDR_W-1:0]   rom_addr
);
  logic [11:0] x_q, y_q;
  logic        en_q, mir_q;

  logic [12:0] h13, v13, x13, y13, dx, dy, col;
  logic        hit;
  logic [ADDR_W-1:0] lin;

  // All compares live in 13 bits so x near 4095 cannot wrap into column 0.
  always_comb begin
    h13 = 13'({2'b00, hcount});
    v13 = 13'({2'b00, vcount});
    x13 = ext13(x_q);
    y13 = ext13(y_q);
    dx  = h13 - x13;
    dy  = v13 - y13;
    hit = en_q && (h13 >= x13) && (v13 >= y13) &&
          (dx < 13'(SPR_W)) && (dy < 13'(SPR_H)) && !blank;
    col = mir_q ? (13'(SPR_W - 1) - dx) : dx;
    lin = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      en_q     <= 1'b0;
      mir_q    <= 1'b0;
      hit_d    <= 1'b0;
      rom_addr <= '0;
    end else begin
      if (load) begin
        x_q   <= xpos;
        y_q   <= ypos;
        en_q  <= en;
        mir_q <= mirror;
      end
      hit_d <= hit;
      if (hit) rom_addr <= lin;
    end
  end
endmodule

// File: rtl/draw_sprites.sv
// N-channel sprite overlay: vsync-shadowed channels, fixed priority, colour key, 2-cycle latency.
module draw_sprites
  import vga_pkg::*;
#(
  parameter int          N_SPR   = 2,
  parameter int          SPR_W   = 48,
  parameter int          SPR_H   = 64,
  parameter int          ADDR_W  = 12,
  parameter logic [11:0] KEY_RGB = SPR_KEY_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  vga_if.in                             vga_in,
  vga_if.out                            vga_out,
  input  logic [N_SPR-1:0][11:0]        xpos,
  input  logic [N_SPR-1:0][11:0]        ypos,
  input  logic [N_SPR-1:0]              spr_en,
  input  logic [N_SPR-1:0]              mirror,
  output logic [N_SPR-1:0][ADDR_W-1:0]  rom_addr,
  input  logic [N_SPR-1:0][11:0]        rom_pixel
);
  if ((2 ** ADDR_W) < (SPR_W * SPR_H)) begin : g_addr_chk
    $error("ADDR_W too small for SPR_W*SPR_H");
  end

  vga_t s0, s1, s2, s2_nxt;
  logic vsync_q, frame_load, blank;
  logic [N_SPR-1:0] hit_d;
  logic [11:0] pix;

  always_comb begin
    s0.vcount = vga_in.vcount;
    s0.vsync  = vga_in.vsync;
    s0.vblnk  = vga_in.vblnk;
    s0.hcount = vga_in.hcount;
    s0.hsync  = vga_in.hsync;
    s0.hblnk  = vga_in.hblnk;
    s0.rgb    = vga_in.rgb;
  end

  assign frame_load = vga_in.vsync & ~vsync_q;
  assign blank      = vga_in.hblnk | vga_in.vblnk;

  for (genvar g = 0; g < N_SPR; g++) begin : g_spr
    sprite_unit #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .ADDR_W(ADDR_W)
    ) u_spr (
      .clk     (clk),
      .rst     (rst),
      .load    (frame_load),
      .xpos    (xpos[g]),
      .ypos    (ypos[g]),
      .en      (spr_en[g]),
      .mirror  (mirror[g]),
      .hcount  (vga_in.hcount),
      .vcount  (vga_in.vcount),
      .blank   (blank),
      .hit_d   (hit_d[g]),
      .rom_addr(rom_addr[g])
    );
  end

  // Walk from lowest priority up so channel 0 is written last and wins.
  always_comb begin
    pix = s1.rgb;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (hit_d[i] && (rom_pixel[i] != KEY_RGB)) pix = rom_pixel[i];
    s2_nxt     = s1;
    s2_nxt.rgb = pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      s1      <= '0;
      s2      <= '0;
    end else begin
      vsync_q <= vga_in.vsync;
      s1      <= s0;
      s2      <= s2_nxt;
    end
  end

  assign vga_out.vcount = s2.vcount;
  assign vga_out.vsync  = s2.vsync;
  assign vga_out.vblnk  = s2.vblnk;
  assign vga_out.hcount = s2.hcount;
  assign vga_out.hsync  = s2.hsync;
  assign vga_out.hblnk  = s2.hblnk;
  assign vga_out.rgb    = s2.rgb;
endmodule
